// File: rtl/tile_sequencer_pkg.sv
// Shared types and helpers for the tile sequencer: FSM state encoding, tile-count
// ceil-divide, last-tile lane enable and modulo address stepping.
// No timing of its own; pure declarations and combinational functions.
package Acc_types;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_WAIT_ACT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

  // Lane enable for the last output-column tile; a zero remainder means a full tile.
  function automatic logic lane_on(input int unsigned lane, input int unsigned w,
                                   input int unsigned dim);
    int unsigned rem;
    rem = w % dim;
    return (rem == 0) || (lane < rem);
  endfunction

  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned m);
    int unsigned s;
    s = a + b;
    return (s >= m) ? (s - m) : s;
  endfunction

endpackage

// File: rtl/acc_write_pipe.sv
// Delay line carrying accumulator write valid/address/add/mask from issue to MAC output.
// Latency: LAT cycles of enabled clocks from vld_i to vld_o.
// Backpressure: en_i low freezes every stage; pending_o reports any valid in flight.
module acc_write_pipe #(
  parameter int LAT   = 8,
  parameter int AW    = 4,
  parameter int LANES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic [AW-1:0]    addr_i,
  input  logic             add_i,
  input  logic [LANES-1:0] mask_i,
  output logic             vld_o,
  output logic [AW-1:0]    addr_o,
  output logic             add_o,
  output logic [LANES-1:0] mask_o,
  output logic             pending_o
);

  logic [LAT-1:0]   vld_sr;
  logic [LAT-1:0]   add_sr;
  logic [AW-1:0]    addr_sr [LAT];
  logic [LANES-1:0] mask_sr [LAT];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_sr <= '0;
      add_sr <= '0;
      for (int i = 0; i < LAT; i++) begin
        addr_sr[i] <= '0;
        mask_sr[i] <= '0;
      end
    end else if (en_i) begin
      vld_sr[0]  <= vld_i;
      add_sr[0]  <= add_i;
      addr_sr[0] <= addr_i;
      mask_sr[0] <= mask_i;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        add_sr[i]  <= add_sr[i-1];
        addr_sr[i] <= addr_sr[i-1];
        mask_sr[i] <= mask_sr[i-1];
      end
    end
  end

  assign vld_o     = vld_sr[LAT-1];
  assign add_o     = add_sr[LAT-1];
  assign addr_o    = addr_sr[LAT-1];
  assign mask_o    = mask_sr[LAT-1];
  assign pending_o = |vld_sr;

endmodule

// File: rtl/tile_sequencer.sv
// Walks a job over w-tiles (outer) and k-tiles (inner): weight load, activation stream, accumulator writes.
// Latency: each streamed row produces its accumulator write MAC_LAT cycles after issue.
// Backpressure: weight_fifo_valid_i gates weight loads, act_rdy_i gates streaming, stall_i freezes everything.
module tile_sequencer
  import Acc_types::*;
#(
  parameter int ARRAY_DIM  = 32,
  parameter int DIM_W      = 9,
  parameter int ACC_DEPTH  = 128,
  parameter int UB_AW      = 12,
  parameter int MAC_LAT    = 2 * ARRAY_DIM,
  localparam int ACC_AW    = $clog2(ACC_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DIM_W-1:0]     H_DIM_i,
  input  logic [DIM_W-1:0]     W_DIM_i,
  input  logic [DIM_W-1:0]     K_DIM_i,
  input  logic [UB_AW-1:0]     ub_base_i,
  input  logic [ACC_AW-1:0]    acc_base_i,
  input  logic                 weight_fifo_valid_i,
  input  logic                 act_rdy_i,
  input  logic                 stall_i,
  output logic                 load_weights_o,
  output logic                 load_activations_o,
  output logic                 MAC_compute_o,
  output logic [UB_AW-1:0]     ub_addr_rd_o,
  output logic                 acc_wr_o,
  output logic                 acc_add_o,
  output logic [ACC_AW-1:0]    acc_addr_wr_o,
  output logic [ARRAY_DIM-1:0] acc_addr_mask_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int WL_W = $clog2(ARRAY_DIM + 1);

  state_t               state;
  logic [DIM_W-1:0]     h_q, nw_q, nk_q;
  logic [DIM_W-1:0]     w_tile, k_tile, row;
  logic [WL_W-1:0]      wl_cnt;
  logic [UB_AW-1:0]     ub_base_q, ub_ptr;
  logic [ACC_AW-1:0]    acc_w_base, acc_ptr;
  logic [ARRAY_DIM-1:0] last_mask_q;
  logic                 err_q;

  logic                 lw_fire, issue, start_ok;
  logic                 row_last, last_k, last_w;
  logic [31:0]          rows_needed;
  logic [DIM_W-1:0]     nw_in, nk_in;
  logic [ARRAY_DIM-1:0] last_mask_in, mask_now;
  logic [ACC_AW-1:0]    acc_ptr_nxt, acc_w_nxt;

  logic                 pipe_vld, pipe_add, pipe_pending;
  logic [ACC_AW-1:0]    pipe_addr;
  logic [ARRAY_DIM-1:0] pipe_mask;

  always_comb begin
    nw_in        = DIM_W'(ceil_div(32'(W_DIM_i), ARRAY_DIM));
    nk_in        = DIM_W'(ceil_div(32'(K_DIM_i), ARRAY_DIM));
    rows_needed  = 32'(H_DIM_i) * 32'(nw_in);
    start_ok     = (H_DIM_i != '0) && (W_DIM_i != '0) && (K_DIM_i != '0)
                   && (rows_needed <= 32'(ACC_DEPTH));
    last_mask_in = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      last_mask_in[i] = lane_on(i, 32'(W_DIM_i), ARRAY_DIM);
    end
    lw_fire     = (state == ST_LOAD_W) && weight_fifo_valid_i && !stall_i;
    issue       = (state == ST_STREAM) && !stall_i;
    row_last    = (row == h_q - 1'b1);
    last_k      = (k_tile == nk_q - 1'b1);
    last_w      = (w_tile == nw_q - 1'b1);
    mask_now    = last_w ? last_mask_q : '1;
    acc_ptr_nxt = ACC_AW'(wrap_add(32'(acc_ptr), 32'd1, ACC_DEPTH));
    acc_w_nxt   = ACC_AW'(wrap_add(32'(acc_w_base), 32'(h_q), ACC_DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      h_q         <= '0;
      nw_q        <= '0;
      nk_q        <= '0;
      w_tile      <= '0;
      k_tile      <= '0;
      row         <= '0;
      wl_cnt      <= '0;
      ub_base_q   <= '0;
      ub_ptr      <= '0;
      acc_w_base  <= '0;
      acc_ptr     <= '0;
      last_mask_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!stall_i) begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              if (start_ok) begin
                h_q         <= H_DIM_i;
                nw_q        <= nw_in;
                nk_q        <= nk_in;
                last_mask_q <= last_mask_in;
                ub_base_q   <= ub_base_i;
                ub_ptr      <= ub_base_i;
                acc_w_base  <= acc_base_i;
                acc_ptr     <= acc_base_i;
                w_tile      <= '0;
                k_tile      <= '0;
                row         <= '0;
                wl_cnt      <= '0;
                state       <= ST_LOAD_W;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_LOAD_W: begin
            if (lw_fire) begin
              if (wl_cnt == WL_W'(ARRAY_DIM - 1)) begin
                wl_cnt <= '0;
                state  <= ST_WAIT_ACT;
              end else begin
                wl_cnt <= wl_cnt + 1'b1;
              end
            end
          end
          ST_WAIT_ACT: begin
            if (act_rdy_i) state <= ST_STREAM;
          end
          ST_STREAM: begin
            ub_ptr  <= ub_ptr + 1'b1;
            acc_ptr <= acc_ptr_nxt;
            if (!row_last) begin
              row <= row + 1'b1;
            end else begin
              row <= '0;
              // Next tile's weights load while this tile's writes are still in the pipe.
              if (!last_k) begin
                k_tile  <= k_tile + 1'b1;
                acc_ptr <= acc_w_base;
                state   <= ST_LOAD_W;
              end else begin
                k_tile <= '0;
                ub_ptr <= ub_base_q;
                if (last_w) begin
                  state <= ST_DRAIN;
                end else begin
                  w_tile     <= w_tile + 1'b1;
                  acc_w_base <= acc_w_nxt;
                  acc_ptr    <= acc_w_nxt;
                  state      <= ST_LOAD_W;
                end
              end
            end
          end
          ST_DRAIN: begin
            if (!pipe_pending) state <= ST_DONE;
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  acc_write_pipe #(
    .LAT   (MAC_LAT),
    .AW    (ACC_AW),
    .LANES (ARRAY_DIM)
  ) u_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (!stall_i),
    .vld_i     (issue),
    .addr_i    (acc_ptr),
    .add_i     (k_tile != '0),
    .mask_i    (mask_now),
    .vld_o     (pipe_vld),
    .addr_o    (pipe_addr),
    .add_o     (pipe_add),
    .mask_o    (pipe_mask),
    .pending_o (pipe_pending)
  );

  assign load_weights_o     = lw_fire;
  assign load_activations_o = issue;
  assign MAC_compute_o      = issue;
  assign ub_addr_rd_o       = ub_ptr;
  assign acc_wr_o           = pipe_vld && !stall_i;
  assign acc_add_o          = pipe_vld && pipe_add && !stall_i;
  assign acc_addr_wr_o      = pipe_addr;
  assign acc_addr_mask_o    = pipe_mask;
  assign busy_o             = (state != ST_IDLE);
  assign done_o             = (state == ST_DONE) && !stall_i;
  assign err_o              = err_q;

endmodule
